subtractor_serial_n: RTL and testbench

//  Digit-serial unsigned subtractor: diff = a - b over nb_bit operands.

---
 rtl/subtractor_serial_n_pkg.sv | 25 ++
 rtl/subtractor_serial_n_sub_digit.sv | 24 ++
 rtl/subtractor_serial_n.sv | 152 +++++++++++++++
 tb/tb_subtractor_serial_n.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/subtractor_serial_n_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
//
// Contents:
//   state_t    - FSM states {IDLE, RUN, NEG, DONE}. NEG is reachable only when
//                SUBTRACTOR_SERIAL_ABS_EN is defined.
//   nb_digits  - number of digits N that make up an operand.
//   cnt_width  - digit counter width, $clog2(N) with a minimum of 1 bit.
package subtractor_serial_n_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int nb_digits(input int nb_bit, input int nb_digit);
        return nb_bit / nb_digit;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subtractor_serial_n_sub_digit.sv
// Combinational nb_digit-bit subtractor slice with borrow in and borrow out.
// The serial top instantiates one slice and reuses it for every digit.
//
// Ports:
//   a_i      in  nb_digit  minuend digit
//   b_i      in  nb_digit  subtrahend digit
//   borrow_i in  1         borrow from the next-lower digit
//   diff_o   out nb_digit  difference digit
//   borrow_o out 1         borrow into the next-higher digit
module sub_digit #(
    parameter int nb_digit = 8
) (
    input  logic [nb_digit-1:0] a_i,
    input  logic [nb_digit-1:0] b_i,
    input  logic                borrow_i,
    output logic [nb_digit-1:0] diff_o,
    output logic                borrow_o
);

    // One extra bit on the left: the (nb_digit+1)-bit result is negative
    // exactly when this digit needs to borrow, so its top bit is the borrow.
    assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i} - {{nb_digit{1'b0}}, borrow_i};

endmodule

// File: rtl/subtractor_serial_n.sv
// Digit-serial unsigned subtractor: diff = a - b over nb_bit operands,
// nb_digit bits per clock, LSB digit first, ripple borrow held in a flop.
//
// Configuration macro:
//   SUBTRACTOR_SERIAL_ABS_EN - when defined, diff_o = |a - b|; a NEG cycle is
//   inserted after RUN only for results that borrowed. borrow_o still gives
//   the sign (1 iff a < b). When undefined, diff_o is the wrapped a - b.
//
// Ports:
//   clk_i    in  1       clock, rising edge
//   rst_i    in  1       synchronous reset, active-high
//   valid_i  in  1       a_i/b_i present
//   ready_o  out 1       operands are accepted this cycle (IDLE or DONE)
//   a_i      in  nb_bit  minuend, unsigned
//   b_i      in  nb_bit  subtrahend, unsigned
//   valid_o  out 1       one-cycle pulse, diff_o/borrow_o are new
//   diff_o   out nb_bit  result, held until the next valid_o
//   borrow_o out 1       1 iff a < b, held with diff_o
module subtractor_serial_n
    import subtractor_serial_n_pkg::*;
#(
    parameter int nb_bit   = 24,
    parameter int nb_digit = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [nb_bit-1:0] a_i,
    input  logic [nb_bit-1:0] b_i,
    output logic              valid_o,
    output logic [nb_bit-1:0] diff_o,
    output logic              borrow_o
);

    localparam int               N     = nb_digits(nb_bit, nb_digit);
    localparam int               CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    if (nb_bit % nb_digit != 0) begin : g_bad_width
        $error("subtractor_serial_n: nb_bit (%0d) must be a multiple of nb_digit (%0d)",
               nb_bit, nb_digit);
    end

    state_t                       state;
    state_t                       state_nxt;
    logic [CNT_W-1:0]             cnt;
    logic                         bin;
    logic [N-1:0][nb_digit-1:0]   a_reg;
    logic [N-1:0][nb_digit-1:0]   b_reg;
    logic [N-1:0][nb_digit-1:0]   result;
    logic [N-1:0][nb_digit-1:0]   res_merged;
    logic [nb_digit-1:0]          d;
    logic                         bout;
    logic                         accept;
    logic                         last;

    assign ready_o = (state == IDLE) || (state == DONE);
    assign valid_o = (state == DONE);
    assign accept  = valid_i && ready_o;
    assign last    = (cnt == LAST);

    sub_digit #(
        .nb_digit (nb_digit)
    ) u_digit (
        .a_i      (a_reg[cnt]),
        .b_i      (b_reg[cnt]),
        .borrow_i (bin),
        .diff_o   (d),
        .borrow_o (bout)
    );

    // Result with the digit computed this cycle already in place, so the
    // last RUN cycle can publish the complete word without waiting a cycle.
    always_comb begin
        res_merged      = result;
        res_merged[cnt] = d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
`ifdef SUBTRACTOR_SERIAL_ABS_EN
                    state_nxt = bout ? NEG : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
            NEG: begin
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = accept ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control and published outputs: cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt      <= '0;
            bin      <= 1'b0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            bin <= 1'b0;
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
            bin <= bout;
            if (last && (state_nxt == DONE)) begin
                diff_o   <= res_merged;
                borrow_o <= bout;
            end
        end else if (state == NEG) begin
            // Only entered after a borrow, so bin is 1 here and stays the sign.
            diff_o   <= ~result + nb_bit'(1);
            borrow_o <= bin;
        end
    end

    // Operand and partial-result storage: pure data, no reset needed.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            a_reg <= a_i;
            b_reg <= b_i;
        end
        if (state == RUN) begin
            result <= res_merged;
        end
    end

endmodule

// File: tb/tb_subtractor_serial_n.sv
// Self-checking bench for subtractor_serial_n (nb_bit=24, nb_digit=8).
// A monitor records every accepted operand pair; a compare process checks
// valid_o, ready_o, diff_o and borrow_o on every cycle against a plain
// arithmetic model. Directed tests pin the model with literal expectations.
// Honours SUBTRACTOR_SERIAL_ABS_EN the same way the design does.
module tb_subtractor_serial_n;

    localparam int NB = 24;
    localparam int ND = 8;
    localparam int N  = NB / ND;
`ifdef SUBTRACTOR_SERIAL_ABS_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    logic          clk;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [NB-1:0] a_i;
    logic [NB-1:0] b_i;
    logic          valid_o;
    logic [NB-1:0] diff_o;
    logic          borrow_o;

    subtractor_serial_n #(
        .nb_bit   (NB),
        .nb_digit (ND)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .valid_o  (valid_o),
        .diff_o   (diff_o),
        .borrow_o (borrow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        int            t;
    } op_t;

    op_t           q[$];
    int            cyc     = 0;
    bit            started = 1'b0;
    logic [NB-1:0] last_d  = '0;
    logic          last_b  = 1'b0;

    function automatic logic [NB-1:0] model_diff(input logic [NB-1:0] a, input logic [NB-1:0] b);
        if (ABS && (a < b)) return b - a;
        return a - b;
    endfunction

    function automatic int model_lat(input logic [NB-1:0] a, input logic [NB-1:0] b);
        return N + 1 + ((ABS && (a < b)) ? 1 : 0);
    endfunction

    // Monitor: sees inputs and ready_o as they were just before the edge.
    initial begin : mon
        forever begin
            @(posedge clk);
            if (rst_i) begin
                q.delete();
                last_d  = '0;
                last_b  = 1'b0;
                started = 1'b1;
            end else if (valid_i && ready_o) begin
                q.push_back('{a_i, b_i, cyc});
            end
            cyc++;
        end
    end

    // Compare: every falling edge once reset has been seen.
    initial begin : cmp
        bit exp_v;
        int due;
        forever begin
            @(negedge clk);
            if (started) begin
                exp_v = 1'b0;
                if (q.size() > 0) begin
                    due = q[0].t + model_lat(q[0].a, q[0].b);
                    if (cyc > due) begin
                        total++;
                        bad++;
                        $display("FAIL model_timeout: result for a=%0h b=%0h missing, due %0d now %0d",
                                 q[0].a, q[0].b, due, cyc);
                        void'(q.pop_front());
                    end else begin
                        exp_v = (cyc == due);
                    end
                end
                chk("model_valid_o", valid_o, exp_v);
                chk("model_ready_o", ready_o, (q.size() == 0) || exp_v);
                if (exp_v) begin
                    last_d = model_diff(q[0].a, q[0].b);
                    last_b = (q[0].a < q[0].b);
                    void'(q.pop_front());
                end
                chk("model_diff_o", diff_o, last_d);
                chk("model_borrow_o", borrow_o, last_b);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Presents operands, waits for acceptance, drops valid_i; returns at the
    // first falling edge after the accepting edge.
    task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            total++;
            bad++;
            $display("FAIL accept: ready_o stayed %0b for %0d cycles", ready_o, n);
        end
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_res(input string name, input logic [NB-1:0] exp_d,
                            input logic exp_b, input int exp_lat);
        int k;
        k = 1;
        while (!valid_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_latency"}, k, exp_lat);
        chk({name, "_diff"}, diff_o, exp_d);
        chk({name, "_borrow"}, borrow_o, exp_b);
    endtask

    initial begin : drv
        int            pulses;
        int            prev;
        int            seen;
        logic [NB-1:0] ra;
        logic [NB-1:0] rb;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        a_i     = '0;
        b_i     = '0;

        // Reset held for two edges
        repeat (2) @(negedge clk);
        chk("reset_ready", ready_o, 1);
        chk("reset_valid", valid_o, 0);
        chk("reset_diff", diff_o, 0);
        chk("reset_borrow", borrow_o, 0);
        rst_i = 1'b0;

        // Directed vectors with literal expectations
        send(24'h000010, 24'h000001);
        wait_res("small", 24'h00000F, 1'b0, 4);
        send(24'h010000, 24'h000001);
        wait_res("cross_digit", 24'h00FFFF, 1'b0, 4);
        send(24'h000000, 24'h000001);
        if (ABS) wait_res("underflow", 24'h000001, 1'b1, 5);
        else     wait_res("underflow", 24'hFFFFFF, 1'b1, 4);
        send(24'h123456, 24'h123456);
        wait_res("equal", 24'h000000, 1'b0, 4);
        send(24'hFFFFFF, 24'h000000);
        wait_res("max_minus_zero", 24'hFFFFFF, 1'b0, 4);
        send(24'h000000, 24'hFFFFFF);
        if (ABS) wait_res("zero_minus_max", 24'hFFFFFF, 1'b1, 5);
        else     wait_res("zero_minus_max", 24'h000001, 1'b1, 4);

        // Reset in the middle of RUN aborts without a result
        send(24'h000005, 24'h000003);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_ready", ready_o, 1);
        chk("abort_valid", valid_o, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        chk("abort_no_valid", seen, 0);

        // valid_i held high with changing operands: back-to-back accepts
        pulses = 0;
        prev   = -1;
        @(negedge clk);
        valid_i = 1'b1;
        for (int i = 0; i < 26; i++) begin
            a_i = 24'h800000 | NB'($urandom);
            b_i = 24'h7FFFFF & NB'($urandom);
            @(negedge clk);
            if (valid_o) begin
                if (prev >= 0) chk("b2b_period", i - prev, N + 1);
                prev = i;
                pulses++;
            end
        end
        valid_i = 1'b0;
        chk("b2b_pulses", pulses >= 5, 1);
        repeat (N + 4) @(negedge clk);

        // Random pairs with edge cases mixed in
        for (int i = 0; i < 2000; i++) begin
            ra = NB'($urandom);
            rb = NB'($urandom);
            case (i % 8)
                0: rb = ra;
                1: ra = '1;
                2: rb = '1;
                3: begin ra = '1; rb = '1; end
                4: ra = '0;
                5: rb = '0;
                default: ;
            endcase
            send(ra, rb);
        end
        repeat (N + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
